// File: rtl/alu_pkg.sv
// Shared constants for the datapath ALU: operand width and the 5-bit opcode map.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/alu_div.sv
// Combinational signed divider: restoring division on magnitudes, then sign fix-up.
// Quotient truncates toward zero, remainder follows the dividend's sign.
module alu_div #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic              neg_a;
  logic              neg_b;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W:0]   part;
  logic [DATA_W-1:0] quo_u;
  logic [DATA_W-1:0] rem_u;

  always_comb begin
    neg_a = dividend[DATA_W-1];
    neg_b = divisor[DATA_W-1];
    // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
    mag_a = neg_a ? -dividend : dividend;
    mag_b = neg_b ? -divisor  : divisor;
    part  = '0;
    quo_u = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      part = {part[DATA_W-1:0], mag_a[i]};
      if (part >= {1'b0, mag_b}) begin
        part     = part - {1'b0, mag_b};
        quo_u[i] = 1'b1;
      end
    end
    rem_u = part[DATA_W-1:0];
  end

  always_comb begin
    if (divisor == '0) begin
      quotient  = '1;
      remainder = dividend;
    end else begin
      quotient  = (neg_a ^ neg_b) ? -quo_u : quo_u;
      remainder = neg_a ? -rem_u : rem_u;
    end
  end

endmodule

// File: rtl/alu.sv
// Datapath ALU: opcode mux over add/sub/logic/shift/rotate/mul/div/neg/not and a
// PC-increment mode, with a single registered 64-bit result ({HI, LO}).
module alu #(
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  IncPC,
  input  logic [DATA_W-1:0]     input_a,
  input  logic [DATA_W-1:0]     input_b,
  input  logic [4:0]            opcode,
  output logic [2*DATA_W-1:0]   ALU_result
);

  import alu_pkg::*;

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]            sh;
  logic [SH_W:0]              inv_sh;
  logic [DATA_W-1:0]          ror_v;
  logic [DATA_W-1:0]          rol_v;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]          div_quo;
  logic [DATA_W-1:0]          div_rem;
  logic [DATA_W-1:0]          hi;
  logic [DATA_W-1:0]          lo;
  logic [2*DATA_W-1:0]        result_d;
  logic [2*DATA_W-1:0]        result_q;

  assign sh     = input_b[SH_W-1:0];
  // A shift by the full width yields zero, so a rotate by 0 collapses to A.
  assign inv_sh = (SH_W + 1)'(DATA_W) - {1'b0, sh};
  assign ror_v  = (input_a >> sh) | (input_a << inv_sh);
  assign rol_v  = (input_a << sh) | (input_a >> inv_sh);
  assign prod   = $signed(input_a) * $signed(input_b);

  alu_div #(
    .DATA_W (DATA_W)
  ) u_div (
    .dividend  (input_a),
    .divisor   (input_b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    hi = '0;
    lo = '0;
    if (IncPC) begin
      lo = input_b + DATA_W'(1);
    end else begin
      case (opcode)
        OP_ADD:  lo = input_a + input_b;
        OP_SUB:  lo = input_a - input_b;
        OP_AND:  lo = input_a & input_b;
        OP_OR:   lo = input_a | input_b;
        OP_SHR:  lo = input_a >> sh;
        OP_SHRA: lo = $signed(input_a) >>> sh;
        OP_SHL:  lo = input_a << sh;
        OP_ROR:  lo = ror_v;
        OP_ROL:  lo = rol_v;
        OP_MUL:  {hi, lo} = prod;
        OP_DIV: begin
          hi = div_rem;
          lo = div_quo;
        end
        OP_NEG:  lo = -input_a;
        OP_NOT:  lo = ~input_a;
        default: begin
          hi = '0;
          lo = '0;
        end
      endcase
    end
    result_d = {hi, lo};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign ALU_result = result_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: each scenario drives vectors, pushes the expected
// result to a scoreboard queue, and compares it one clock later.
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        clr;
  logic        IncPC;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic [4:0]  opcode;
  logic [63:0] ALU_result;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    string       name;
    logic        clr;
    logic        inc;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  alu #(.DATA_W(32)) dut (
    .clk        (clk),
    .clr        (clr),
    .IncPC      (IncPC),
    .input_a    (input_a),
    .input_b    (input_b),
    .opcode     (opcode),
    .ALU_result (ALU_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string n, input logic c, input logic i,
                              input logic [4:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [63:0] e);
    vec_t v;
    v.name = n; v.clr = c; v.inc = i; v.op = o; v.a = a; v.b = b; v.exp = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    clr     = v.clr;
    IncPC   = v.inc;
    opcode  = v.op;
    input_a = v.a;
    input_b = v.b;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t v[3];
    logic [63:0] e;
    v[0] = mk("reset_add",     1'b1, 1'b0, OP_ADD, 32'd5, 32'd10, 64'd0);
    v[1] = mk("post_reset",    1'b0, 1'b0, OP_ADD, 32'd5, 32'd10, 64'h0000_0000_0000_000F);
    v[2] = mk("reset_over_pc", 1'b1, 1'b1, OP_MUL, 32'd9, 32'd9,  64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(v[i]);
      e = exp_q.pop_front();
      checks++;
      if (ALU_result !== e) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", v[i].name, ALU_result, e);
      end
    end
  endtask

  task automatic test_logic();
    vec_t v[5];
    logic [63:0] e;
    v[0] = mk("and",   1'b0, 1'b0, OP_AND, 32'd5, 32'd4, 64'd4);
    v[1] = mk("or",    1'b0, 1'b0, OP_OR,  32'd6, 32'd3, 64'd7);
    v[2] = mk("not",   1'b0, 1'b0, OP_NOT, 32'd5, 32'd0, 64'h0000_0000_FFFF_FFFA);
    v[3] = mk("neg",   1'b0, 1'b0, OP_NEG, 32'd5, 32'd0, 64'h0000_0000_FFFF_FFFB);
    v[4] = mk("neg_min", 1'b0, 1'b0, OP_NEG, 32'h8000_0000, 32'd0, 64'h0000_0000_8000_0000);
    for (int i = 0; i < 5; i++) begin
      drive(v[i]);
      e = exp_q.pop_front();
      checks++;
      if (ALU_result !== e) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", v[i].name, ALU_result, e);
      end
    end
  endtask

  task automatic test_arith();
    vec_t v[6];
    logic [63:0] e;
    v[0] = mk("add_neg_pos", 1'b0, 1'b0, OP_ADD, -32'sd5,  32'd8,   64'd3);
    v[1] = mk("add_neg_neg", 1'b0, 1'b0, OP_ADD, -32'sd55, -32'sd10, 64'h0000_0000_FFFF_FFBF);
    v[2] = mk("add_wrap",    1'b0, 1'b0, OP_ADD, 32'hFFFF_FFFF, 32'd2, 64'd1);
    v[3] = mk("sub",         1'b0, 1'b0, OP_SUB, 32'd75, 32'd11, 64'd64);
    v[4] = mk("incpc_wrap",  1'b0, 1'b1, OP_ADD, 32'd123, 32'hFFFF_FFFF, 64'd0);
    v[5] = mk("incpc_over_mul", 1'b0, 1'b1, OP_MUL, 32'd7, 32'h0000_1000, 64'h0000_0000_0000_1001);
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      e = exp_q.pop_front();
      checks++;
      if (ALU_result !== e) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", v[i].name, ALU_result, e);
      end
    end
  endtask

  task automatic test_muldiv();
    vec_t v[8];
    logic [63:0] e;
    v[0] = mk("mul_pos",   1'b0, 1'b0, OP_MUL, 32'd723,   32'd19, 64'h0000_0000_0000_35A9);
    v[1] = mk("mul_neg",   1'b0, 1'b0, OP_MUL, -32'sd723, 32'd19, 64'hFFFF_FFFF_FFFF_CA57);
    v[2] = mk("mul_big",   1'b0, 1'b0, OP_MUL, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    v[3] = mk("div_pos",   1'b0, 1'b0, OP_DIV, 32'd780,   32'd40, {32'd20, 32'd19});
    v[4] = mk("div_neg",   1'b0, 1'b0, OP_DIV, -32'sd780, 32'd40, {32'hFFFF_FFEC, 32'hFFFF_FFED});
    v[5] = mk("div_zero",  1'b0, 1'b0, OP_DIV, 32'd7,     32'd0,  {32'd7, 32'hFFFF_FFFF});
    v[6] = mk("div_minm1", 1'b0, 1'b0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    v[7] = mk("div_negdv", 1'b0, 1'b0, OP_DIV, 32'd7,     -32'sd2, {32'd1, 32'hFFFF_FFFD});
    for (int i = 0; i < 8; i++) begin
      drive(v[i]);
      e = exp_q.pop_front();
      checks++;
      if (ALU_result !== e) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", v[i].name, ALU_result, e);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v[10];
    logic [63:0] e;
    v[0] = mk("shr",       1'b0, 1'b0, OP_SHR,  32'h07, 32'd2, 64'd1);
    v[1] = mk("shra_pos",  1'b0, 1'b0, OP_SHRA, 32'h17, 32'd2, 64'd5);
    v[2] = mk("shra_neg",  1'b0, 1'b0, OP_SHRA, 32'h8000_0000, 32'd4, 64'h0000_0000_F800_0000);
    v[3] = mk("shl",       1'b0, 1'b0, OP_SHL,  32'hEE, 32'd4, 64'hEE0);
    v[4] = mk("ror",       1'b0, 1'b0, OP_ROR,  32'h17, 32'd2, 64'h0000_0000_C000_0005);
    v[5] = mk("rol",       1'b0, 1'b0, OP_ROL,  32'h0E, 32'd4, 64'hE0);
    v[6] = mk("rol_b33",   1'b0, 1'b0, OP_ROL,  32'h8000_0001, 32'd33, 64'd3);
    v[7] = mk("ror_zero",  1'b0, 1'b0, OP_ROR,  32'h1234_5678, 32'h0000_0020, 64'h0000_0000_1234_5678);
    v[8] = mk("shr_hiign", 1'b0, 1'b0, OP_SHR,  32'hF000_0000, 32'hFFFF_FFE4, 64'h0000_0000_0F00_0000);
    v[9] = mk("rol_31",    1'b0, 1'b0, OP_ROL,  32'h0000_0003, 32'd31, 64'h0000_0000_8000_0001);
    for (int i = 0; i < 10; i++) begin
      drive(v[i]);
      e = exp_q.pop_front();
      checks++;
      if (ALU_result !== e) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", v[i].name, ALU_result, e);
      end
    end
  endtask

  task automatic test_undefined();
    vec_t v[3];
    logic [63:0] e;
    v[0] = mk("op_11111", 1'b0, 1'b0, 5'b11111, 32'd5, 32'd4, 64'd0);
    v[1] = mk("op_00000", 1'b0, 1'b0, 5'b00000, 32'hFFFF_FFFF, 32'd1, 64'd0);
    v[2] = mk("op_01100", 1'b0, 1'b0, 5'b01100, 32'd9, 32'd9, 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(v[i]);
      e = exp_q.pop_front();
      checks++;
      if (ALU_result !== e) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", v[i].name, ALU_result, e);
      end
    end
  endtask

  // Output must hold the previous result until the edge, then show the new one.
  task automatic test_back_to_back();
    vec_t v[5];
    logic [63:0] e;
    logic [63:0] prev;
    v[0] = mk("b2b_add", 1'b0, 1'b0, OP_ADD, 32'd1,  32'd2, 64'd3);
    v[1] = mk("b2b_sub", 1'b0, 1'b0, OP_SUB, 32'd10, 32'd4, 64'd6);
    v[2] = mk("b2b_mul", 1'b0, 1'b0, OP_MUL, -32'sd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    v[3] = mk("b2b_pc",  1'b0, 1'b1, OP_NOT, 32'd0,  32'd41, 64'd42);
    v[4] = mk("b2b_clr", 1'b1, 1'b1, OP_ADD, 32'd1,  32'd1, 64'd0);
    prev = ALU_result;
    for (int i = 0; i < 5; i++) begin
      clr = v[i].clr; IncPC = v[i].inc; opcode = v[i].op;
      input_a = v[i].a; input_b = v[i].b;
      exp_q.push_back(v[i].exp);
      #1;
      checks++;
      if (ALU_result !== prev) begin
        errors++;
        $display("FAIL %s_hold got=%h exp=%h", v[i].name, ALU_result, prev);
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (ALU_result !== e) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", v[i].name, ALU_result, e);
      end
      prev = e;
    end
  endtask

  task automatic test_random();
    vec_t v;
    logic [63:0] e;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [63:0] p;
    logic signed [31:0] q;
    logic signed [31:0] r;
    for (int i = 0; i < 40; i++) begin
      sa = $urandom;
      sb = $urandom;
      if (i % 4 == 0) sb = $signed(32'($urandom_range(1, 50))) * ((i % 8 == 0) ? -1 : 1);
      if (sb == 0) sb = 3;
      if (sa == 32'sh8000_0000 && sb == -1) sb = 5;
      if (i % 2 == 0) begin
        p = 64'(sa) * 64'(sb);
        v = mk("rand_mul", 1'b0, 1'b0, OP_MUL, sa, sb, p);
      end else begin
        q = sa / sb;
        r = sa % sb;
        v = mk("rand_div", 1'b0, 1'b0, OP_DIV, sa, sb, {r, q});
      end
      drive(v);
      e = exp_q.pop_front();
      checks++;
      if (ALU_result !== e) begin
        errors++;
        $display("FAIL %s a=%h b=%h got=%h exp=%h", v.name, v.a, v.b, ALU_result, e);
      end
    end
  endtask

  initial begin
    clr     = 1'b1;
    IncPC   = 1'b0;
    opcode  = OP_ADD;
    input_a = '0;
    input_b = '0;
    test_reset();
    test_logic();
    test_arith();
    test_muldiv();
    test_shift();
    test_undefined();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
